// File: rtl/csr_counter_file_pkg.sv
// Shared constants for the CSR counter block: core state code, csr_op encodings
// and the counter CSR address map.
package csr_counter_file_pkg;

    localparam logic [2:0] REG_FILE_READ = 3'd2;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_HPM_BASE      = 12'hC03;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MHPM_BASE     = 12'hB03;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

    // Upper nibble of the address selects the read-only or writable page.
    localparam logic [3:0] PAGE_RO = CSR_CYCLE[11:8];
    localparam logic [3:0] PAGE_RW = CSR_MCYCLE[11:8];

endpackage

// File: rtl/csr_counter_file_if.sv
// CSR access bus between decode (master) and the counter block (slave).
interface csr_counter_file_if;
    logic        en_csr;
    logic [1:0]  csr_op;
    logic [11:0] csr_adr;
    logic [31:0] csr_wdata;
    logic        csr_src_zero;
    logic [31:0] csr_val;
    logic        csr_valid;
    logic        csr_illegal;

    modport master (
        output en_csr, csr_op, csr_adr, csr_wdata, csr_src_zero,
        input  csr_val, csr_valid, csr_illegal
    );

    modport slave (
        input  en_csr, csr_op, csr_adr, csr_wdata, csr_src_zero,
        output csr_val, csr_valid, csr_illegal
    );
endinterface

// File: rtl/csr_counter_file_counter.sv
// One CNT_W-bit event counter with 32-bit half writes; a write on the same
// edge as an increment wins and that increment is dropped.
module csr_counter #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             inhibit,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [31:0]      wdata,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (wr_lo) begin
            cnt <= {cnt[CNT_W-1:32], wdata};
        end else if (wr_hi) begin
            cnt <= {wdata[CNT_W-33:0], cnt[31:0]};
        end else if (inc && !inhibit) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/csr_counter_file.sv
// CSR counter file: cycle/instret/hpm counters with user read-only views,
// machine writable views and mcountinhibit; registered one-cycle read response.
module csr_counter_file
    import csr_counter_file_pkg::*;
#(
    parameter int CNT_W = 64,
    parameter int N_HPM = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [2:0]                          state,
    input  logic                                instr_retire,
    input  logic [(N_HPM > 0 ? N_HPM : 1)-1:0]  hpm_evt,
    csr_counter_file_if.slave                   bus
);
    localparam int NC = 2 + N_HPM;
    localparam logic [31:0] INH_MASK = 32'h5 | (((32'd1 << N_HPM) - 32'd1) << 3);

    logic [CNT_W-1:0] cnt     [NC];
    logic [63:0]      cnt_ext [NC];
    logic [NC-1:0]    inc, inh, wr_lo, wr_hi;
    logic [31:0]      inhibit_q;

    csr_op_e     op;
    logic        access, is_inh, is_ro, is_rw, hi, sel_ok, mapped, we, illegal, do_wr;
    logic [6:0]  lidx;
    logic [2:0]  sel;
    logic [63:0] rd_cnt;
    logic [31:0] old_val, new_val;

    assign op     = csr_op_e'(bus.csr_op);
    assign access = bus.en_csr && (state == REG_FILE_READ) && (op != CSR_OP_NONE);
    assign lidx   = bus.csr_adr[6:0];
    assign hi     = bus.csr_adr[7];
    assign is_inh = (bus.csr_adr == CSR_MCOUNTINHIBIT);
    assign is_ro  = (bus.csr_adr[11:8] == PAGE_RO);
    assign is_rw  = (bus.csr_adr[11:8] == PAGE_RW);

    // Counter slot: 0 = cycle, 1 = instret, 2+i = hpm i (address index 3+i).
    always_comb begin
        sel_ok = 1'b0;
        sel    = '0;
        if (lidx == 7'd0) begin
            sel_ok = 1'b1;
            sel    = 3'd0;
        end else if (lidx == 7'd2) begin
            sel_ok = 1'b1;
            sel    = 3'd1;
        end else if (lidx >= 7'd3 && lidx < 7'(3 + N_HPM)) begin
            sel_ok = 1'b1;
            sel    = 3'(lidx - 7'd1);
        end
    end

    assign mapped  = is_inh || ((is_ro || is_rw) && sel_ok);
    assign we      = (op == CSR_OP_RW) || !bus.csr_src_zero;
    assign illegal = !mapped || (is_ro && we);
    assign do_wr   = access && !illegal && we;

    always_comb begin
        rd_cnt = '0;
        for (int k = 0; k < NC; k++) begin
            if (sel == 3'(k)) rd_cnt = cnt_ext[k];
        end
    end

    assign old_val = is_inh ? inhibit_q : (hi ? rd_cnt[63:32] : rd_cnt[31:0]);

    always_comb begin
        case (op)
            CSR_OP_RS: new_val = old_val | bus.csr_wdata;
            CSR_OP_RC: new_val = old_val & ~bus.csr_wdata;
            default:   new_val = bus.csr_wdata;
        endcase
    end

    always_comb begin
        inc    = '0;
        inh    = '0;
        wr_lo  = '0;
        wr_hi  = '0;
        inc[0] = 1'b1;
        inc[1] = instr_retire;
        inh[0] = inhibit_q[0];
        inh[1] = inhibit_q[2];
        for (int i = 0; i < N_HPM; i++) begin
            inc[2+i] = hpm_evt[i];
            inh[2+i] = inhibit_q[3+i];
        end
        for (int k = 0; k < NC; k++) begin
            wr_lo[k] = do_wr && is_rw && !hi && (sel == 3'(k));
            wr_hi[k] = do_wr && is_rw &&  hi && (sel == 3'(k));
        end
    end

    for (genvar g = 0; g < NC; g++) begin : g_cnt
        csr_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc     (inc[g]),
            .inhibit (inh[g]),
            .wr_lo   (wr_lo[g]),
            .wr_hi   (wr_hi[g]),
            .wdata   (new_val),
            .cnt     (cnt[g])
        );
        assign cnt_ext[g] = 64'(cnt[g]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inhibit_q       <= '0;
            bus.csr_val     <= '0;
            bus.csr_valid   <= 1'b0;
            bus.csr_illegal <= 1'b0;
        end else begin
            if (do_wr && is_inh) inhibit_q <= new_val & INH_MASK;
            bus.csr_valid   <= access;
            bus.csr_illegal <= access && illegal;
            if (access) bus.csr_val <= illegal ? 32'd0 : old_val;
        end
    end
endmodule
